// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the multi-cycle divide controller: state encodings,
// handshake levels and register bus widths.
package div_ctrl_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_ctrl_step.sv
// One radix-2 restoring-divide iteration: trial subtract of the divisor from
// the partial remainder, producing the next remainder bits and a quotient bit.
module div_ctrl_step
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = RegBus
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0] diff_s;

  // trial subtract; a clear borrow bit means the divisor fits
  always_comb begin
    diff_s = part_rem - {1'b0, divisor};
    q_bit  = ~diff_s[WIDTH];
    if (q_bit) begin
      next_rem = diff_s[WIDTH-1:0];
    end else begin
      next_rem = part_rem[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Divide sequencer for DIV/DIVU: latches operand magnitudes, runs WIDTH
// shift-subtract iterations, applies sign fix-up and hands {rem, quot} to ex.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int WIDTH = RegBus,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

  div_state_e          state_r, state_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic [2*WIDTH:0]    dividend_r, dividend_s;
  logic [WIDTH-1:0]    divisor_r, divisor_s;
  logic                signed_r, signed_s;
  logic                a_neg_r, a_neg_s;
  logic                b_neg_r, b_neg_s;
  logic [2*WIDTH-1:0]  result_r, result_s;
  logic                ready_r, ready_s;

  logic                a_neg_in_s, b_neg_in_s;
  logic [WIDTH-1:0]    abs_a_s, abs_b_s;
  logic [WIDTH-1:0]    quot_s, rem_s, quot_fix_s, rem_fix_s;
  logic [WIDTH-1:0]    step_rem_s;
  logic                step_q_s;

  div_ctrl_step #(.WIDTH(WIDTH)) u_step (
    .part_rem (dividend_r[2*WIDTH:WIDTH]),
    .divisor  (divisor_r),
    .next_rem (step_rem_s),
    .q_bit    (step_q_s)
  );

  // operand magnitudes at acceptance and sign correction of the final result
  always_comb begin
    a_neg_in_s = signed_div_i & opdata1_i[WIDTH-1];
    b_neg_in_s = signed_div_i & opdata2_i[WIDTH-1];
    if (a_neg_in_s) begin
      abs_a_s = -opdata1_i;
    end else begin
      abs_a_s = opdata1_i;
    end
    if (b_neg_in_s) begin
      abs_b_s = -opdata2_i;
    end else begin
      abs_b_s = opdata2_i;
    end
    quot_s = dividend_r[WIDTH-1:0];
    rem_s  = dividend_r[2*WIDTH:WIDTH+1];
    if (signed_r && (a_neg_r ^ b_neg_r)) begin
      quot_fix_s = -quot_s;
    end else begin
      quot_fix_s = quot_s;
    end
    if (signed_r && a_neg_r) begin
      rem_fix_s = -rem_s;
    end else begin
      rem_fix_s = rem_s;
    end
  end

  // next-state and next-datapath logic; annul overrides every state
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    dividend_s = dividend_r;
    divisor_s  = divisor_r;
    signed_s   = signed_r;
    a_neg_s    = a_neg_r;
    b_neg_s    = b_neg_r;
    result_s   = result_r;
    ready_s    = ready_r;
    if (annul_i) begin
      state_s  = DivFree;
      cnt_s    = {CNT_W{1'b0}};
      result_s = {(2*WIDTH){1'b0}};
      ready_s  = DivResultNotReady;
    end else begin
      case (state_r)
        DivFree: begin
          result_s = {(2*WIDTH){1'b0}};
          ready_s  = DivResultNotReady;
          if (start_i == DivStart) begin
            if (opdata2_i == {WIDTH{1'b0}}) begin
              state_s = DivByZero;
            end else begin
              state_s    = DivOn;
              cnt_s      = {CNT_W{1'b0}};
              signed_s   = signed_div_i;
              a_neg_s    = a_neg_in_s;
              b_neg_s    = b_neg_in_s;
              divisor_s  = abs_b_s;
              dividend_s = {{WIDTH{1'b0}}, abs_a_s, 1'b0};
            end
          end else begin
            state_s = DivFree;
          end
        end
        DivByZero: begin
          state_s  = DivEnd;
          result_s = {(2*WIDTH){1'b0}};
          ready_s  = DivResultReady;
        end
        DivOn: begin
          if (cnt_r != CNT_LAST) begin
            dividend_s = {step_rem_s, dividend_r[WIDTH-1:0], step_q_s};
            cnt_s      = cnt_r + CNT_ONE;
          end else begin
            state_s  = DivEnd;
            cnt_s    = {CNT_W{1'b0}};
            result_s = {rem_fix_s, quot_fix_s};
            ready_s  = DivResultReady;
          end
        end
        DivEnd: begin
          if (start_i == DivStop) begin
            state_s  = DivFree;
            result_s = {(2*WIDTH){1'b0}};
            ready_s  = DivResultNotReady;
          end else begin
            state_s = DivEnd;
          end
        end
        default: begin
          state_s  = DivFree;
          cnt_s    = {CNT_W{1'b0}};
          result_s = {(2*WIDTH){1'b0}};
          ready_s  = DivResultNotReady;
        end
      endcase
    end
  end

  // state, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= DivFree;
      cnt_r      <= {CNT_W{1'b0}};
      dividend_r <= {(2*WIDTH+1){1'b0}};
      divisor_r  <= {WIDTH{1'b0}};
      signed_r   <= 1'b0;
      a_neg_r    <= 1'b0;
      b_neg_r    <= 1'b0;
      result_r   <= {(2*WIDTH){1'b0}};
      ready_r    <= DivResultNotReady;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      dividend_r <= dividend_s;
      divisor_r  <= divisor_s;
      signed_r   <= signed_s;
      a_neg_r    <= a_neg_s;
      b_neg_r    <= b_neg_s;
      result_r   <= result_s;
      ready_r    <= ready_s;
    end
  end

  assign result_o = result_r;
  assign ready_o  = ready_r;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Multi-cycle divide controller and datapath that sequences the shared radix-2 iterative divider for DIV/DIVU. The EX stage drives operands and a start/signed request; this block runs 32 shift-subtract iterations and returns {remainder, quotient} for HI/LO writeback with a ready handshake. Pipeline flush annuls an in-flight divide. The block sits beside ex, and ex holds the stall request while the result is not ready.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH.
CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
signed_div_i  in  1  1 = signed DIV, 0 = DIVU; sampled with start
opdata1_i  in  WIDTH  dividend
opdata2_i  in  WIDTH  divisor
start_i  in  1  divide request (DivStart); ex holds it high until it has consumed ready
annul_i  in  1  flush; cancels any operation
result_o  out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}
ready_o  out  1  DivResultReady

Behaviour:
- Reset values: state = FREE, result_o = 0, ready_o = 0, counter = 0.
- All outputs are registered.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start_i=1, annul_i=0, divisor==0 -> BYZERO.
  - start_i=1, annul_i=0, divisor!=0 -> ON. On this edge (E0), latch signed flag and operand magnitudes:
    - signed mode: two's-complement negate any negative operand.
    - unsigned mode: use operands as-is.
    - Initialise dividend register to {WIDTH zeros, |dividend|, 1'b0} (shifted once) and clear the counter.
  - start_i=1 and annul_i=1 together: annul wins, stay FREE.
- ON, one iteration per edge E1..E32:
  - Trial subtract: partial_remainder[2W:W] - {0,|divisor|}.
  - Non-negative: shift in quotient bit 1 and keep the difference.
  - Negative: shift in 0 and keep the partial remainder.
  - Counter increments each iteration.
  - On edge E33 (counter == WIDTH): apply sign correction, then move to END with result_o and ready_o=1.
    - Quotient is negated if signed and sign(dividend) != sign(divisor).
    - Remainder is negated if signed and the dividend is negative.
  - ready_o is first visible after E33, i.e. 33 edges after start is accepted.
- BYZERO: next edge -> END with result_o = 0 and ready_o = 1. ready_o is visible after E1.
- END:
  - Hold result_o and ready_o stable while start_i = 1.
  - start_i = 0 -> FREE on the next edge, with ready_o = 0 and result_o = 0.
- annul_i = 1 in ON, BYZERO or END -> FREE on the next edge, with result_o = 0, ready_o = 0 and counter cleared. No partial result is ever presented.
- Operand changes after acceptance are ignored; latched values are used.
- Signed overflow case 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0. No trap.
- Unsigned ops never negate.
- Synchronous rst mid-operation behaves like annul and additionally has priority over annul.
- Back-to-back divides: minimum gap is one FREE cycle (the start_i low cycle).

Decomposition:
- Shared defines package:
  - DivFree, DivByZero, DivOn, DivEnd (2-bit state encodings).
  - DivResultReady, DivResultNotReady.
  - DivStart, DivStop.
  - DoubleRegBus, RegBus widths.
- One natural sub-module: div_step, purely combinational. It performs one trial subtract + shift (inputs: partial remainder, divisor; outputs: next partial remainder, quotient bit).
- The FSM, counter and sign fix-up stay in div_ctrl.

Test Plan:
- DIVU 7 / 2 -> after 33 edges, ready_o=1 and result_o = 64'h00000001_00000003. Ready stays stable while start is held. Dropping start gives ready_o=0 and result_o=0 next cycle.
- DIV -7 (0xFFFFFFF9) / 2 -> result_o = 64'hFFFFFFFF_FFFFFFFD. Check also 7 / -2 -> 64'h00000001_FFFFFFFD.
- Divisor 0 (any dividend, either mode) -> BYZERO, ready_o=1 after 2 edges, result_o = 0.
- Annul asserted at iteration 10 of 0x12345678 / 3 -> FREE next edge, ready never rises. A fresh start of 100 / 7 then yields 64'h00000002_0000000E.
- DIV 0x80000000 / 0xFFFFFFFF -> result_o = 64'h00000000_80000000. DIVU 0xFFFFFFFF / 1 -> 64'h00000000_FFFFFFFF.
- rst pulsed while in ON, and start+annul asserted together in FREE -> state FREE, all outputs 0, no ready pulse.
